// File: rtl/uart_echo_responder.sv
// Buffers characters received from a UART Rx and echoes them back through a UART Tx, in order.
// Optional build macro ECHO_ERR_DROP_EN: discard parity/stop-error characters and count them.
module uart_echo_responder #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_W     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       rx_done_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic                       tx_busy_i,
  input  logic                       tx_done_i,
  output logic                       tx_start_o,
  output logic [MAX_UART_DATA_W-1:0] tx_data_o,
  output logic [FIFO_ADDR_W:0]       fifo_count_o,
  output logic                       overflow_o,
  output logic [7:0]                 err_drop_cnt_o
);

`ifdef ECHO_ERR_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [MAX_UART_DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_W-1:0]     r_wr_ptr;
  logic [FIFO_ADDR_W-1:0]     r_rd_ptr;
  logic [FIFO_ADDR_W:0]       r_count;
  logic [MAX_UART_DATA_W-1:0] r_tx_data;
  logic                       r_overflow;
  logic [7:0]                 r_err_cnt;

  logic w_full;
  logic w_empty;
  logic w_rx_flagged;
  logic w_drop;
  logic w_rx_take;
  logic w_pop;
  logic w_push;
  logic w_overflow_set;

  assign w_full       = (r_count == (FIFO_ADDR_W+1)'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_rx_flagged = rx_parity_err_i | rx_stop_err_i;
  assign w_drop       = DROP_EN & rx_done_i & en_i & w_rx_flagged;
  assign w_rx_take    = rx_done_i & en_i & ~w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a simultaneous push.
  assign w_pop          = (r_state == IDLE) & en_i & ~w_empty & ~tx_busy_i;
  assign w_push         = w_rx_take & (~w_full | w_pop);
  assign w_overflow_set = w_rx_take & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_overflow_set) begin
        r_overflow <= 1'b1;
      end
      if (w_drop && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_pop) w_state_next = START;
      START:     if (tx_busy_i || tx_done_i) w_state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done_i) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_start_o = (r_state == START);
  end

  assign tx_data_o      = r_tx_data;
  assign fifo_count_o   = r_count;
  assign overflow_o     = r_overflow;
  assign err_drop_cnt_o = DROP_EN ? r_err_cnt : 8'd0;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed self-checking bench for uart_echo_responder; the Tx side is driven by hand.
module tb_uart_echo_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_perr = 1'b0;
  logic       rx_serr = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] fifo_count;
  logic       overflow;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_echo_responder #(
    .MAX_UART_DATA_W(8),
    .FIFO_DEPTH(16),
    .FIFO_ADDR_W(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .rx_done_i      (rx_done),
    .rx_data_i      (rx_data),
    .rx_parity_err_i(rx_perr),
    .rx_stop_err_i  (rx_serr),
    .tx_busy_i      (tx_busy),
    .tx_done_i      (tx_done),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .fifo_count_o   (fifo_count),
    .overflow_o     (overflow),
    .err_drop_cnt_o (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_char(input logic [7:0] d, input logic pe = 1'b0, input logic se = 1'b0);
    rx_done = 1'b1;
    rx_data = d;
    rx_perr = pe;
    rx_serr = se;
    tick();
    rx_done = 1'b0;
    rx_perr = 1'b0;
    rx_serr = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_start && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(tx_start), 32'd1);
    check(tag, 32'(tx_data), 32'(exp));
  endtask

  // Tx accepts the character: busy rises, then a done pulse a few cycles later.
  task automatic finish_tx(input string tag);
    tx_busy = 1'b1;
    tick();
    check({tag, "_start_drop"}, 32'(tx_start), 32'd0);
    tick();
    tick();
    tx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    en = 1'b1;

    // Single character, Tx idle: start appears two cycles after rx_done
    rx_char(8'h41);
    check("c36_count_after_push", 32'(fifo_count), 32'd1);
    check("c36_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    check("c36_start", 32'(tx_start), 32'd1);
    check("c36_data", 32'(tx_data), 32'h41);
    finish_tx("c36");

    // Three characters buffered while Tx busy, then echoed in order
    tx_busy = 1'b1;
    rx_char(8'h01);
    rx_char(8'h02);
    rx_char(8'h03);
    check("c37_count", 32'(fifo_count), 32'd3);
    tx_busy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_start($sformatf("c37_echo%0d", i), 8'(i));
      finish_tx($sformatf("c37_echo%0d", i));
    end

    // Overflow: 17 characters with Tx stalled
    tx_busy = 1'b1;
    for (int i = 0; i < 17; i++) rx_char(8'(8'h10 + i));
    check("c38_count_full", 32'(fifo_count), 32'd16);
    check("c38_overflow", 32'(overflow), 32'd1);
    // Push and pop in the same cycle while full: count unchanged
    rx_done = 1'b1;
    rx_data = 8'h30;
    tx_busy = 1'b0;
    tick();
    rx_done = 1'b0;
    check("c27_count_push_pop_full", 32'(fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      wait_start($sformatf("c38_echo%0d", i), 8'(8'h10 + i));
      finish_tx($sformatf("c38_echo%0d", i));
    end
    wait_start("c38_echo_last", 8'h30);
    finish_tx("c38_echo_last");
    tick();
    tick();
    check("c38_drained_count", 32'(fifo_count), 32'd0);
    check("c38_no_17th", 32'(tx_start), 32'd0);
    check("c38_overflow_sticky", 32'(overflow), 32'd1);

    // Error-flagged character
    rx_char(8'h55, 1'b1, 1'b0);
`ifdef ECHO_ERR_DROP_EN
    tick();
    tick();
    check("c39_not_buffered", 32'(fifo_count), 32'd0);
    check("c39_no_start", 32'(tx_start), 32'd0);
    check("c39_err_cnt", 32'(err_cnt), 32'd1);
    rx_char(8'h56, 1'b0, 1'b1);
    check("c39_err_cnt_stop", 32'(err_cnt), 32'd2);
`else
    wait_start("c39_echo", 8'h55);
    finish_tx("c39_echo");
    check("c39_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Enable gating: buffered characters held while disabled, rx ignored
    tx_busy = 1'b1;
    rx_char(8'h61);
    rx_char(8'h62);
    en = 1'b0;
    tx_busy = 1'b0;
    rx_char(8'h63);
    for (int i = 0; i < 4; i++) tick();
    check("c41_no_start", 32'(tx_start), 32'd0);
    check("c41_count_held", 32'(fifo_count), 32'd2);
    en = 1'b1;
    wait_start("c41_echo1", 8'h61);
    finish_tx("c41_echo1");
    wait_start("c41_echo2", 8'h62);
    finish_tx("c41_echo2");

    // Asynchronous reset during START
    tx_busy = 1'b1;
    rx_char(8'h71);
    rx_char(8'h72);
    tx_busy = 1'b0;
    wait_start("c40_pre", 8'h71);
    check("c40_count_pre", 32'(fifo_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("c40_tx_start", 32'(tx_start), 32'd0);
    check("c40_count", 32'(fifo_count), 32'd0);
    check("c40_tx_data", 32'(tx_data), 32'd0);
    check("c40_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("c40_idle_after", 32'(tx_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
UART_ECHO_RESPONDER -- requirements
Module: uart_echo_responder

Interface
REQ-001 SHALL have parameter MAX_UART_DATA_W, default 8, UART character width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, echo buffer entries (power of two, >=2).
REQ-003 SHALL have parameter FIFO_ADDR_W, default 4, equal to log2(FIFO_DEPTH).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en_i  input  1  responder enable.
REQ-007 SHALL have port rx_done_i  input  1  one-cycle pulse from UART Rx, character received.
REQ-008 SHALL have port rx_data_i  input  MAX_UART_DATA_W  received character, valid with rx_done_i.
REQ-009 SHALL have port rx_parity_err_i  input  1  parity error flag, valid with rx_done_i.
REQ-010 SHALL have port rx_stop_err_i  input  1  stop error flag, valid with rx_done_i.
REQ-011 SHALL have port tx_busy_i  input  1  UART Tx busy status.
REQ-012 SHALL have port tx_done_i  input  1  one-cycle pulse from UART Tx, character sent.
REQ-013 SHALL have port tx_start_o  output  1  start request to UART Tx.
REQ-014 SHALL have port tx_data_o  output  MAX_UART_DATA_W  character to transmit, registered.
REQ-015 SHALL have port fifo_count_o  output  FIFO_ADDR_W+1  entries currently buffered.
REQ-016 SHALL have port overflow_o  output  1  sticky flag, character lost to full buffer.
REQ-017 SHALL have port err_drop_cnt_o  output  8  count of error-flagged characters discarded.

Function
REQ-018 SHALL push rx_data_i into the FIFO on the cycle rx_done_i=1, en_i=1, FIFO not full.
REQ-019 SHALL, on rx_done_i=1 with en_i=1 and FIFO full, discard the character and set overflow_o; overflow_o clears only on reset.
REQ-020 SHALL ignore rx_done_i while en_i=0.
REQ-021 SHALL implement FSM states IDLE, START, WAIT_DONE; reset state IDLE.
REQ-022 SHALL, in IDLE with en_i=1, FIFO not empty and tx_busy_i=0, pop the head into tx_data_o and enter START next cycle.
REQ-023 SHALL drive tx_start_o=1 for every cycle in START and 0 in all other states.
REQ-024 SHALL leave START for WAIT_DONE on the first cycle tx_busy_i=1 or tx_done_i=1.
REQ-025 SHALL leave WAIT_DONE for IDLE on tx_done_i=1; the next pop is no earlier than the cycle after.
REQ-026 SHALL hold tx_data_o stable from pop until return to IDLE.
REQ-027 SHALL, on simultaneous push and pop with FIFO full, accept the push; fifo_count_o unchanged.
REQ-028 SHALL, on simultaneous push and pop with FIFO empty, not pop; character becomes available next cycle.
REQ-029 SHALL wrap read/write pointers modulo FIFO_DEPTH; fifo_count_o ranges 0..FIFO_DEPTH.
REQ-030 SHALL, when en_i falls mid-transmission, complete the current character, then remain in IDLE retaining FIFO contents.
REQ-031 SHALL echo characters in reception order with no reordering or duplication.

Reset
REQ-032 SHALL, on rst_ni=0, immediately clear: FSM->IDLE, pointers and fifo_count_o->0, tx_start_o->0, tx_data_o->0, overflow_o->0, err_drop_cnt_o->0.
REQ-033 SHALL abandon any in-flight character when reset asserts mid-operation; FIFO storage contents need not be cleared.

Configuration
REQ-034 SHALL, with macro ECHO_ERR_DROP_EN defined, discard characters received with rx_parity_err_i=1 or rx_stop_err_i=1 and increment err_drop_cnt_o, saturating at 255.
REQ-035 SHALL, without ECHO_ERR_DROP_EN, buffer error-flagged characters like any other and tie err_drop_cnt_o to 0.

Verification
REQ-036 SHALL cover: rx 0x41 with Tx idle -> tx_start_o rises 2 cycles after rx_done_i, tx_data_o=0x41, drops when tx_busy_i=1.
REQ-037 SHALL cover: 3 rx (0x01,0x02,0x03) while tx_busy_i=1 -> fifo_count_o=3, echoed 0x01,0x02,0x03 in order, one per tx_done_i.
REQ-038 SHALL cover: 17 rx with Tx stalled, FIFO_DEPTH=16 -> fifo_count_o=16, overflow_o=1, 17th character never echoed.
REQ-039 SHALL cover: ECHO_ERR_DROP_EN defined, rx 0x55 with rx_parity_err_i=1 -> not buffered, err_drop_cnt_o=1; undefined -> 0x55 echoed, err_drop_cnt_o=0.
REQ-040 SHALL cover: rst_ni low asynchronously during START -> tx_start_o=0 and fifo_count_o=0 before next clock edge.
REQ-041 SHALL cover: en_i=0 with 2 buffered characters -> no tx_start_o; en_i=1 -> both echoed in order.
